// File: rtl/operand_scoreboard_if.sv
// Decode/writeback handshake bundle between the pipeline and the operand scoreboard.
interface operand_scoreboard_if;
    logic       id_valid;
    logic       id_ready;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] id_rd;
    logic       id_rd_we;
    logic [4:0] raddr1;
    logic [4:0] raddr2;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       flush;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_rd_we,
        output wb_valid, wb_rd, flush,
        input  id_ready, raddr1, raddr2
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_rd_we,
        input  wb_valid, wb_rd, flush,
        output id_ready, raddr1, raddr2
    );
endinterface

// File: rtl/operand_scoreboard.sv
// Decode-stage register busy tracker: RAW/WAW hazard check, in-flight write limit, WB bypass.
// Optional SCOREBOARD_PERF_EN adds a saturating stall_cnt output.
module operand_scoreboard #(
    parameter int MAX_INFLIGHT = 4,
    parameter int NREGS        = 32,
    localparam int CW          = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    operand_scoreboard_if.slave  sb,
    output logic [NREGS-1:0]     busy_vec,
`ifdef SCOREBOARD_PERF_EN
    output logic [31:0]          stall_cnt,
`endif
    output logic [CW-1:0]        inflight_cnt,
    output logic                 wb_err
);
    logic [NREGS-1:0] busy, busy_eff, busy_nxt;
    logic [CW-1:0]    cnt_eff;
    logic             clr, set, hazard, full, issue, wb_bad;

    assign sb.raddr1 = sb.id_rs1;
    assign sb.raddr2 = sb.id_rs2;

    assign clr    = sb.wb_valid & (sb.wb_rd != 5'd0) & busy[sb.wb_rd] & ~sb.flush;
    assign wb_bad = sb.wb_valid & (sb.wb_rd != 5'd0) & ~busy[sb.wb_rd] & ~sb.flush;

    // A register retiring this cycle is already visible to Decode (negedge regfile write).
    always_comb begin
        busy_eff = busy;
        if (clr) busy_eff[sb.wb_rd] = 1'b0;
    end

    assign hazard = (sb.id_use_rs1 & busy_eff[sb.id_rs1])
                  | (sb.id_use_rs2 & busy_eff[sb.id_rs2])
                  | (sb.id_rd_we & (sb.id_rd != 5'd0) & busy_eff[sb.id_rd]);

    assign cnt_eff     = inflight_cnt - CW'(clr);
    assign full        = sb.id_rd_we & (sb.id_rd != 5'd0) & (cnt_eff == CW'(MAX_INFLIGHT));
    assign sb.id_ready = rst_n & ~sb.flush & ~hazard & ~full;
    assign issue       = sb.id_valid & sb.id_ready;
    assign set         = issue & sb.id_rd_we & (sb.id_rd != 5'd0);

    // Set after clear so a same-cycle retire+reissue of one index leaves it busy.
    always_comb begin
        busy_nxt = busy_eff;
        if (set) busy_nxt[sb.id_rd] = 1'b1;
        if (sb.flush) busy_nxt = '0;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy         <= '0;
            inflight_cnt <= '0;
            wb_err       <= 1'b0;
        end else begin
            busy         <= busy_nxt;
            inflight_cnt <= sb.flush ? '0 : inflight_cnt + CW'(set) - CW'(clr);
            if (wb_bad) wb_err <= 1'b1;
        end
    end

    assign busy_vec = busy;

`ifdef SCOREBOARD_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (sb.id_valid & ~sb.id_ready & ~sb.flush & (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif
endmodule
